// File: rtl/pacman_pkg.sv
// Shared types for the Pac-Man motion block: directions, FSM states and the
// direction-to-sprite-orientation mapping used by the renderer.
package pacman_pkg;

    localparam int SPRITE_WIDTH  = 8;
    localparam int SPRITE_HEIGHT = 8;

    typedef enum logic [1:0] {
        DIR_RIGHT,
        DIR_LEFT,
        DIR_UP,
        DIR_DOWN
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_Q_WANT,
        S_Q_CUR,
        S_COMMIT,
        S_HALT
    } motion_state_t;

    // Returns {h_flip, v_flip} for the renderer.
    function automatic logic [1:0] dir_to_flip(input dir_t dir);
        logic [1:0] flip;
        flip = 2'b01;
        case (dir)
            DIR_RIGHT: flip = 2'b11;
            DIR_LEFT:  flip = 2'b01;
            DIR_DOWN:  flip = 2'b10;
            DIR_UP:    flip = 2'b00;
            default:   flip = 2'b01;
        endcase
        return flip;
    endfunction

endpackage

// File: rtl/pacman_dir_arbiter.sv
// Turns the four player buttons into the buffered desired direction.
// Define PACMAN_MOTION_SYNC_EN to pass the buttons through 2-flop synchronizers.
module pacman_dir_arbiter
    import pacman_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic btn_up_i,
    input  logic btn_down_i,
    input  logic btn_left_i,
    input  logic btn_right_i,
    output dir_t want_dir_o
);

    logic [3:0] btns;
    dir_t       wantDir_q;
    dir_t       wantDir_d;

`ifdef PACMAN_MOTION_SYNC_EN
    logic [3:0] sync1_q;
    logic [3:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_up_i, btn_down_i, btn_left_i, btn_right_i};
            sync2_q <= sync1_q;
        end
    end

    assign btns = sync2_q;
`else
    assign btns = {btn_up_i, btn_down_i, btn_left_i, btn_right_i};
`endif

    // With no button held the last request stays buffered, so a turn can be
    // pressed early and taken at the first opening.
    always_comb begin
        wantDir_d = wantDir_q;
        if (btns[3])      wantDir_d = DIR_UP;
        else if (btns[2]) wantDir_d = DIR_DOWN;
        else if (btns[1]) wantDir_d = DIR_LEFT;
        else if (btns[0]) wantDir_d = DIR_RIGHT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wantDir_q <= DIR_LEFT;
        else     wantDir_q <= wantDir_d;
    end

    assign want_dir_o = wantDir_q;

endmodule

// File: rtl/pacman_motion.sv
// Pac-Man sprite motion: per step, try the buffered turn, then straight, else stop.
// Define PACMAN_MOTION_SYNC_EN to synchronize the button inputs.
module pacman_motion
    import pacman_pkg::*;
#(
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 216,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 280,
    parameter int START_X     = 104,
    parameter int START_Y     = 204,
    parameter int STEP_FRAMES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       query_valid,
    output logic [8:0] query_x,
    output logic [8:0] query_y,
    input  logic       query_ready,
    input  logic       query_blocked,
    output logic [8:0] x_pac,
    output logic [8:0] y_pac,
    output logic       h_flip,
    output logic       v_flip,
    output logic       moving,
    output logic       overrun
);

    localparam int CntW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

    motion_state_t  state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    dir_t           stepDir_q, stepDir_d;
    dir_t           curDir_q, curDir_d;
    logic [8:0]     x_q, x_d, y_q, y_d;
    logic [1:0]     flip_q, flip_d;
    logic           moving_q, moving_d;
    logic           overrun_q, overrun_d;
    dir_t           wantDir;
    logic [8:0]     candX, candY;
    logic           locBlk;
    logic           blockedNow;

    pacman_dir_arbiter u_arbiter (
        .clk        (clk),
        .rst        (rst),
        .btn_up_i   (btn_up),
        .btn_down_i (btn_down),
        .btn_left_i (btn_left),
        .btn_right_i(btn_right),
        .want_dir_o (wantDir)
    );

    // stepDir_q holds the direction under test, so the candidate stays stable
    // for the whole handshake even if buttons change meanwhile.
    always_comb begin
        candX  = x_q;
        candY  = y_q;
        locBlk = 1'b0;
        case (stepDir_q)
            DIR_LEFT:  candX = (x_q == 9'(X_MIN)) ? 9'(X_MAX) : x_q - 9'd1;
            DIR_RIGHT: candX = (x_q == 9'(X_MAX)) ? 9'(X_MIN) : x_q + 9'd1;
            DIR_UP:    if (y_q == 9'(Y_MIN)) locBlk = 1'b1; else candY = y_q - 9'd1;
            DIR_DOWN:  if (y_q == 9'(Y_MAX)) locBlk = 1'b1; else candY = y_q + 9'd1;
            default:   locBlk = 1'b1;
        endcase
    end

    assign query_valid = ((state_q == S_Q_WANT) || (state_q == S_Q_CUR)) && !locBlk;
    assign query_x     = candX;
    assign query_y     = candY;
    assign blockedNow  = locBlk || (query_ready && query_blocked);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stepDir_d = stepDir_q;
        curDir_d  = curDir_q;
        x_d       = x_q;
        y_d       = y_q;
        flip_d    = flip_q;
        moving_d  = moving_q;
        overrun_d = overrun_q | (frame_tick && (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    if (cnt_q == CntW'(STEP_FRAMES - 1)) begin
                        cnt_d     = '0;
                        stepDir_d = wantDir;
                        state_d   = S_Q_WANT;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            S_Q_WANT: begin
                if (blockedNow) begin
                    if (stepDir_q == curDir_q) begin
                        state_d = S_HALT;
                    end else begin
                        stepDir_d = curDir_q;
                        state_d   = S_Q_CUR;
                    end
                end else if (query_ready) begin
                    state_d = S_COMMIT;
                end
            end
            S_Q_CUR: begin
                if (blockedNow)       state_d = S_HALT;
                else if (query_ready) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                x_d      = candX;
                y_d      = candY;
                curDir_d = stepDir_q;
                flip_d   = dir_to_flip(stepDir_q);
                moving_d = 1'b1;
                state_d  = S_IDLE;
            end
            S_HALT: begin
                moving_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            stepDir_q <= DIR_LEFT;
            curDir_q  <= DIR_LEFT;
            x_q       <= 9'(START_X);
            y_q       <= 9'(START_Y);
            flip_q    <= dir_to_flip(DIR_LEFT);
            moving_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stepDir_q <= stepDir_d;
            curDir_q  <= curDir_d;
            x_q       <= x_d;
            y_q       <= y_d;
            flip_q    <= flip_d;
            moving_q  <= moving_d;
            overrun_q <= overrun_d;
        end
    end

    assign x_pac   = x_q;
    assign y_pac   = y_q;
    assign h_flip  = flip_q[1];
    assign v_flip  = flip_q[0];
    assign moving  = moving_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_pacman_motion.sv
// Self-checking bench for pacman_motion: directed scenarios plus a randomized
// walk, all checked against a step-level reference model kept in the bench.
module tb_pacman_motion;

    localparam int X_MIN = 0, X_MAX = 216, Y_MIN = 0, Y_MAX = 280;
    localparam int START_X = 104, START_Y = 204;
    localparam int DR = 0, DL = 1, DU = 2, DD = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       btn_up, btn_down, btn_left, btn_right;
    logic       query_valid;
    logic [8:0] query_x, query_y;
    logic       query_ready, query_blocked;
    logic [8:0] x_pac, y_pac;
    logic       h_flip, v_flip, moving, overrun;

    int checks   = 0;
    int failures = 0;
    int hsCount  = 0;
    int hsBase;
    int mx, my, mCur, mWant;
    bit mMoving, mOverrun;

    pacman_motion dut (
        .clk          (clk),
        .rst          (rst),
        .frame_tick   (frame_tick),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .query_valid  (query_valid),
        .query_x      (query_x),
        .query_y      (query_y),
        .query_ready  (query_ready),
        .query_blocked(query_blocked),
        .x_pac        (x_pac),
        .y_pac        (y_pac),
        .h_flip       (h_flip),
        .v_flip       (v_flip),
        .moving       (moving),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (query_valid === 1'b1 && query_ready === 1'b1) hsCount++;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Where one pixel step in direction d from the model position would land.
    task automatic candOf(input int d, output int cx, output int cy, output bit loc);
        int span;
        span = X_MAX - X_MIN + 1;
        cx = mx; cy = my; loc = 0;
        case (d)
            DR: cx = X_MIN + ((mx - X_MIN + 1) % span);
            DL: cx = X_MIN + ((mx - X_MIN - 1 + span) % span);
            DU: begin cy = my - 1; loc = (cy < Y_MIN); end
            default: begin cy = my + 1; loc = (cy > Y_MAX); end
        endcase
    endtask

    function automatic int flipOf(input int d);
        case (d)
            DR: return 3;
            DL: return 1;
            DD: return 2;
            default: return 0;
        endcase
    endfunction

    task automatic pressButtons(input bit [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        repeat (3) @(negedge clk);
        if (b[3])      mWant = DU;
        else if (b[2]) mWant = DD;
        else if (b[1]) mWant = DL;
        else if (b[0]) mWant = DR;
    endtask

    task automatic serveQuery(input string tag, input int ex, input int ey, input bit blk,
                              input int stall, input bit tickStall);
        int n;
        n = 0;
        while (query_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        checkOutput({tag, "_valid"}, query_valid, 1);
        if (query_valid !== 1'b1) return;
        checkOutput({tag, "_qx"}, query_x, ex);
        checkOutput({tag, "_qy"}, query_y, ey);
        for (int i = 0; i < stall; i++) begin
            query_ready = 1'b0;
            frame_tick  = tickStall && (i == 1);
            @(negedge clk);
            frame_tick = 1'b0;
            checkOutput({tag, "_stall_valid"}, query_valid, 1);
            checkOutput({tag, "_stall_qx"}, query_x, ex);
            checkOutput({tag, "_stall_qy"}, query_y, ey);
        end
        query_ready   = 1'b1;
        query_blocked = blk;
        @(negedge clk);
        query_ready   = 1'b0;
        query_blocked = 1'b0;
    endtask

    // One full step: tick, answer the expected queries, then compare outputs.
    task automatic applyStimulus(input bit blkWant, input bit blkCur, input int stall, input bit tickStall);
        int wx, wy, cx, cy, dir, nQ;
        bit wLoc, cLoc, done;
        candOf(mWant, wx, wy, wLoc);
        candOf(mCur, cx, cy, cLoc);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        done = 0;
        dir  = -1;
        if (!wLoc) begin
            serveQuery("want", wx, wy, blkWant, stall, tickStall);
            if (!blkWant) begin dir = mWant; done = 1; end
        end
        if (!done && mWant != mCur && !cLoc) begin
            serveQuery("cur", cx, cy, blkCur, 0, 0);
            if (!blkCur) dir = mCur;
        end
        nQ = 0;
        repeat (4) begin @(negedge clk); if (query_valid === 1'b1) nQ++; end
        checkOutput("stray_query", nQ, 0);
        if (dir == mWant) begin mx = wx; my = wy; end
        else if (dir >= 0) begin mx = cx; my = cy; end
        if (dir >= 0) mCur = dir;
        mMoving = (dir >= 0);
        if (tickStall && stall >= 2) mOverrun = 1;
        checkOutput("x_pac", x_pac, mx);
        checkOutput("y_pac", y_pac, my);
        checkOutput("flips", {h_flip, v_flip}, flipOf(mCur));
        checkOutput("moving", moving, mMoving);
        checkOutput("overrun", overrun, mOverrun);
    endtask

    task automatic modelReset();
        mx = START_X; my = START_Y; mCur = DL; mWant = DL; mMoving = 0; mOverrun = 0;
    endtask

    initial begin
        int hs;
        rst = 1'b1; frame_tick = 1'b0; query_ready = 1'b0; query_blocked = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_x", x_pac, START_X);
        checkOutput("rst_y", y_pac, START_Y);
        checkOutput("rst_flips", {h_flip, v_flip}, 1);
        checkOutput("rst_moving", moving, 0);
        checkOutput("rst_valid", query_valid, 0);

        // Stuck in the first query with ready low, then reset mid-request.
        frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
        checkOutput("wait_valid", query_valid, 1);
        checkOutput("wait_qx", query_x, 103);
        frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
        checkOutput("wait_overrun", overrun, 1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", query_valid, 0);
        checkOutput("midrst_x", x_pac, START_X);
        checkOutput("midrst_y", y_pac, START_Y);
        checkOutput("midrst_flips", {h_flip, v_flip}, 1);
        checkOutput("midrst_overrun", overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        modelReset();

        // Latency with ready held high: new position three cycles after the tick.
        hsBase = hsCount;
        frame_tick = 1'b1; query_ready = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checkOutput("lat_valid", query_valid, 1);
        checkOutput("lat_qx", query_x, 103);
        @(negedge clk);
        query_ready = 1'b0;
        checkOutput("lat_early_x", x_pac, 104);
        @(negedge clk);
        checkOutput("lat_x", x_pac, 103);
        checkOutput("lat_moving", moving, 1);
        mx = 103; mMoving = 1;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("free_queries", hsCount - hsBase, 3);
        checkOutput("free_x", x_pac, 101);

        // Buffered turn: up blocked first, then taken on the next step.
        pressButtons(4'b1000);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) pressButtons(4'($urandom_range(1, 15)));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 2), 0);
        end

        // Tunnel wrap in both directions.
        pressButtons(4'b0010);
        for (int i = 0; i < 300 && mx != X_MIN; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("tunnel_left", x_pac, X_MAX);
        pressButtons(4'b0001);
        applyStimulus(0, 0, 0, 0);
        checkOutput("tunnel_right", x_pac, X_MIN);

        // Top wall: local block with no query, then both moves blocked by the maze.
        pressButtons(4'b1000);
        for (int i = 0; i < 300 && my != Y_MIN; i++) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("wall_moving", moving, 0);
        checkOutput("wall_y", y_pac, 0);
        pressButtons(4'b0100);
        applyStimulus(0, 0, 0, 0);
        pressButtons(4'b0010);
        applyStimulus(1, 1, 0, 0);
        checkOutput("both_blocked_moving", moving, 0);

        // Stalled responder with a tick arriving mid-stall.
        applyStimulus(0, 0, 5, 1);
        hs = hsCount;
        repeat (8) @(negedge clk);
        checkOutput("one_step_queries", hsCount - hs, 0);
        checkOutput("one_step_x", x_pac, mx);
        checkOutput("overrun_sticky", overrun, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pacman_motion.md
Name: pacman_motion

Overview:
Produces the Pac-Man sprite position (x_pac, y_pac) and orientation (h_flip, v_flip) that the sprite renderer consumes. Once per step period it latches the player's desired direction from the buttons and asks the maze responder, over a valid/ready query, whether the candidate next pixel is blocked. Like the arcade game, it prefers the buffered turn, falls back to continuing straight, and stops when both moves are blocked. It sits between input/maze logic and the sprite renderer and updates position only on frame boundaries.

Parameters:
X_MIN, 0, leftmost legal x_pac
X_MAX, 216, rightmost legal x_pac (tunnel wrap partner of X_MIN)
Y_MIN, 0, topmost legal y_pac
Y_MAX, 280, bottommost legal y_pac
START_X, 104, x_pac after reset
START_Y, 204, y_pac after reset
STEP_FRAMES, 1, frame_tick pulses per 1-pixel step (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
btn_up / btn_down / btn_left / btn_right  in  1 each  player buttons, active-high
query_valid  out  1  maze query request
query_x  out  9  candidate x, stable while query_valid=1
query_y  out  9  candidate y, stable while query_valid=1
query_ready  in  1  responder accepts; query_blocked sampled this cycle
query_blocked  in  1  1 = candidate pixel is wall
x_pac  out  9  sprite x
y_pac  out  9  sprite y
h_flip  out  1  orientation bit to renderer
v_flip  out  1  orientation bit to renderer
moving  out  1  last step committed a move
overrun  out  1  sticky: a step came due while the FSM was busy

Behaviour:
- Reset (async, immediate):
  - x_pac=START_X, y_pac=START_Y
  - cur_dir=want_dir=LEFT, so h_flip=0, v_flip=1
  - query_valid=0, moving=0, overrun=0
  - FSM=IDLE, frame counter=0
  - Reset during WAIT drops query_valid at once; the responder tolerates an abandoned request.
- Direction-to-flip map: RIGHT h=1,v=1; LEFT h=0,v=1; DOWN h=1,v=0; UP h=0,v=0.
- want_dir update:
  - Every cycle a pressed button overwrites want_dir.
  - Priority: up > down > left > right.
  - No button pressed: want_dir holds.
- Step due:
  - In IDLE, each frame_tick increments the counter.
  - On the tick where counter==STEP_FRAMES-1, the counter clears and the FSM goes to Q_WANT next cycle.
  - A frame_tick while the FSM is not IDLE sets overrun; the tick is not counted.
- Candidate position:
  - x moves ±1 with tunnel wrap: LEFT at X_MIN gives X_MAX; RIGHT at X_MAX gives X_MIN.
  - y moves ±1; stepping beyond Y_MIN or Y_MAX is treated as blocked locally, with no query issued.
- FSM states: IDLE, Q_WANT, Q_CUR, COMMIT, HALT.
  - IDLE: wait for a step to come due.
  - Q_WANT:
    - Assert query_valid with the want_dir candidate; hold until query_ready.
    - Not blocked: COMMIT with want_dir.
    - Blocked: go to Q_CUR, or straight to HALT when want_dir==cur_dir.
    - A locally-blocked candidate goes to Q_CUR/HALT with query_valid kept low.
  - Q_CUR: same as Q_WANT using cur_dir. Not blocked goes to COMMIT with cur_dir; blocked goes to HALT.
  - COMMIT: register new x_pac/y_pac, set cur_dir to the chosen direction, update flips, moving=1, then IDLE.
  - HALT: position and orientation unchanged, moving=0, then IDLE.
- query_valid deasserts in the cycle after the ready handshake.
- Outputs are registered: a new position is visible the cycle after COMMIT.
- Latency with query_ready tied high: 3 cycles from the due tick to the new x_pac.

Optional Feature:
- Macro: PACMAN_MOTION_SYNC_EN.
- Defined: each button passes through a 2-flop synchronizer; want_dir lags the pins by 2 cycles.
- Undefined: buttons are used directly; they are required to be synchronous to clk.

Decomposition:
- Package pacman_pkg:
  - dir_t enum (DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN)
  - motion_state_t enum
  - SPRITE_WIDTH=8, SPRITE_HEIGHT=8
  - function dir_to_flip returning {h_flip, v_flip}
- One sub-module, pacman_dir_arbiter: optional synchronizer plus priority encoder plus the want_dir register.

Test Plan:
- Reset mid Q_WANT (query_valid=1, ready=0): assert rst → query_valid=0 combinationally; x_pac=104, y_pac=204, h_flip=0, v_flip=1, overrun=0.
- Free run, ready=1, blocked=0, no buttons, 3 frame_ticks → x_pac=101, y_pac=204, moving=1, exactly 3 queries with query_x=103, 102, 101.
- Buffered turn: press btn_up once.
  - Tick 1, UP query blocked → second query x=103; LEFT commits; flips stay 0/1.
  - Tick 2, UP clear → y_pac=203, h_flip=0, v_flip=0.
- Tunnel: x_pac=0 moving LEFT → query_x=216, commit x_pac=216; x_pac=216 moving RIGHT → 0.
- Wall stop: y_pac=0 with cur=want=UP → no query issued, HALT, moving=0, position held; both directions blocked by the responder → same result.
- Stall/overrun: query_ready low for 5 cycles → query_x/query_y stable; frame_tick during the stall → overrun=1 (sticky) and only one step taken.
